gray_frame_ctrl: RTL and testbench
==================================

Name: gray_frame_ctrl

Overview:
Frame-level controller for the programmable RGB-to-gray converter in the video pipeline.
- Accepts coefficient updates from the control bus at any time.
- Commits them to the converter only at frame boundaries, so a frame is never converted with mixed coefficients.
- Gates the pixel stream into the converter and checks incoming video geometry.
- Sits between the sensor/timing source and the converter's coefficient and valid inputs.

Parameters:
H_ACT, 640, active pixels per line expected
V_ACT, 480, active lines per frame expected
CW, 12, width of pixel and line counters (must hold H_ACT and V_ACT)
COEF_SUM, 256, required sum of C0+C1+C2 (unity gain, Q0.8)
RST_C0 / RST_C1 / RST_C2, 76 / 150 / 29, coefficient values after reset

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
cfg_en  in  1  1 = run conversion; 0 = stop at end of current frame
cfg_wr  in  1  one-cycle strobe; loads cfg_coef into pending register
cfg_coef  in  24  {C0[23:16], C1[15:8], C2[7:0]}
err_clr  in  1  clears sticky error flags
i_vsync  in  1  frame sync, active-high; rising edge = frame start
i_valid  in  1  source pixel valid
o_c0 / o_c1 / o_c2  out  8 each  committed coefficients to converter
o_pix_en  out  1  gated valid to converter = i_valid AND (state==ACTIVE), combinational
o_frame_done  out  1  one-cycle pulse when an ACTIVE frame closes
o_frame_cnt  out  16  frames completed, wraps 0xFFFF->0
o_cfg_err  out  1  one-cycle pulse: rejected coefficient write
o_err_line  out  1  sticky: a line had pixel count != H_ACT
o_err_frame  out  1  sticky: a frame had line count != V_ACT
o_busy  out  1  1 while state != IDLE

Behaviour:
- Reset values:
  - state IDLE; o_c0/1/2 = RST_C0/1/2; pending = RST values, pending_vld=0.
  - Counters 0; all pulses and flags 0; o_pix_en=0.
- Edge detection: registered copies vs_d, val_d. vs_rise = i_vsync & ~vs_d; line_end = val_d & ~i_valid.
- States:
  - IDLE -> WAIT_VS when cfg_en=1.
  - WAIT_VS -> ACTIVE on vs_rise; WAIT_VS -> IDLE if cfg_en=0.
  - ACTIVE, on vs_rise with cfg_en=1: close frame, reopen, stay ACTIVE.
  - ACTIVE, on vs_rise with cfg_en=0: close frame -> IDLE.
- Mid-frame behaviour: cfg_en deassertion never truncates a frame. Pixels keep flowing until the next vs_rise.
- Close frame (same cycle as vs_rise, registered effect next cycle):
  - o_frame_done=1 and o_frame_cnt+1, but only if the frame being closed was ACTIVE.
  - line_cnt != V_ACT sets o_err_frame.
  - line_cnt and pix_cnt clear.
- Coefficient commit: on every vs_rise in WAIT_VS or ACTIVE, if pending_vld, then o_cX <= pending and pending_vld <= 0. New values therefore apply from the first pixel of the new frame.
- cfg_wr:
  - If C0+C1+C2 (10-bit sum) == COEF_SUM: pending <= cfg_coef, pending_vld <= 1. A later write overwrites an earlier uncommitted one.
  - Else: o_cfg_err pulses next cycle and pending is unchanged.
  - cfg_wr coincident with vs_rise: the old pending value commits, and the new write becomes pending for the next frame.
- Counting, ACTIVE only:
  - pix_cnt++ per i_valid, saturating at all-ones.
  - On line_end: if pix_cnt (including the current cycle's pixel) != H_ACT, set o_err_line. Then line_cnt++ (saturating) and pix_cnt <= 0.
  - A line still open at vs_rise is counted as a line, with the same pixel check.
- Error flags: err_clr clears both flags. If err_clr coincides with a new error event, the error wins (flag stays 1).
- o_frame_cnt wraps modulo 2^16.
- Reset mid-frame returns everything to reset values on the next edge. o_pix_en drops immediately because the state becomes IDLE.

Decomposition:
- Shared package gray_pkg holds:
  - state enum (IDLE, WAIT_VS, ACTIVE)
  - COEF_W=8, COEF_SUM, RST_C0..C2
  - coefficient pack/unpack field positions
- One natural sub-module: video_geom_chk. It contains the edge detect, pix/line counters and error flag generation. The top keeps the FSM and coefficient shadowing.

Test Plan:
- Reset, cfg_en=1, two 640x480 frames:
  - o_pix_en stays 0 until the first vsync rise.
  - o_frame_done pulses once (at the second vs_rise).
  - o_frame_cnt=1; both error flags 0.
- cfg_wr {100,100,56} mid-frame 1:
  - o_c0/1/2 stay 76/150/29 until the next vs_rise.
  - Then 100/100/56 from the next cycle.
- cfg_wr {100,100,100} (sum 300):
  - o_cfg_err pulses one cycle.
  - Pending and outputs are unchanged at the next frame boundary.
- Line of 639 pixels, then err_clr:
  - o_err_line=1 after line end.
  - A frame with 479 lines sets o_err_frame at vs_rise.
  - err_clr clears both flags.
- cfg_en=0 on line 100 of a frame:
  - o_pix_en continues through line 479.
  - At the next vs_rise, o_frame_done pulses and the state goes IDLE (o_busy=0).
  - Later pixels are gated.
- rst asserted mid-line: next cycle all outputs are at reset values, o_frame_cnt=0, and o_c0/1/2=76/150/29.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and constants for the RGB-to-gray frame controller.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam int COEF_W      = 8;
  localparam int COEF_PACK_W = 3 * COEF_W;
  localparam int COEF_SUM    = 256;

  localparam int RST_C0 = 76;
  localparam int RST_C1 = 150;
  localparam int RST_C2 = 29;

  // Field positions inside the packed {C0, C1, C2} word
  localparam int C0_LSB = 2 * COEF_W;
  localparam int C1_LSB = COEF_W;
  localparam int C2_LSB = 0;

  localparam logic [COEF_PACK_W-1:0] RST_COEF =
    {COEF_W'(RST_C0), COEF_W'(RST_C1), COEF_W'(RST_C2)};

  // Sum of the three coefficients, wide enough that it never overflows
  function automatic logic [9:0] coef_sum(input logic [COEF_PACK_W-1:0] w);
    return 10'(w[C0_LSB +: COEF_W]) + 10'(w[C1_LSB +: COEF_W]) + 10'(w[C2_LSB +: COEF_W]);
  endfunction

endpackage

// File: rtl/video_geom_chk.sv
// Video geometry checker: vsync/valid edge detect, pixel and line counters,
// sticky line/frame length error flags. Counts only while active_i is high.
module video_geom_chk #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CW    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic vsync_i,
  input  logic valid_i,
  input  logic err_clr_i,
  output logic vs_rise_o,
  output logic err_line_o,
  output logic err_frame_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          vs_d_q, val_d_q;
  logic [CW-1:0] pix_cnt_q, line_cnt_q;
  logic          err_line_q, err_frame_q;

  logic          line_end, line_close;
  logic [CW-1:0] pix_now, line_now;
  logic          line_evt, frame_evt;

  // Edge detect and end-of-line / end-of-frame evaluation.
  // A line still open when vsync rises is closed and checked like any other.
  always_comb begin
    vs_rise_o  = vsync_i & ~vs_d_q;
    line_end   = val_d_q & ~valid_i;
    pix_now    = (valid_i && (pix_cnt_q != CNT_MAX)) ? pix_cnt_q + 1'b1 : pix_cnt_q;
    line_close = line_end | (vs_rise_o & (pix_now != '0));
    line_now   = (line_close && (line_cnt_q != CNT_MAX)) ? line_cnt_q + 1'b1 : line_cnt_q;
    line_evt   = active_i & line_close & (pix_now != CW'(H_ACT));
    frame_evt  = active_i & vs_rise_o & (line_now != CW'(V_ACT));
  end

  // Delayed copies, counters and sticky flags; a new error beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_q      <= 1'b0;
      val_d_q     <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      vs_d_q  <= vsync_i;
      val_d_q <= valid_i;
      if (!active_i || vs_rise_o) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
      end else if (line_end) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= line_now;
      end else begin
        pix_cnt_q  <= pix_now;
      end
      err_line_q  <= line_evt  | (err_line_q  & ~err_clr_i);
      err_frame_q <= frame_evt | (err_frame_q & ~err_clr_i);
    end
  end

  assign err_line_o  = err_line_q;
  assign err_frame_o = err_frame_q;

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame-level controller for the RGB-to-gray converter: frame FSM, coefficient
// shadowing with commit at frame boundaries, pixel gating and frame counting.
module gray_frame_ctrl
  import gray_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CW    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic                   cfg_wr,
  input  logic [COEF_PACK_W-1:0] cfg_coef,
  input  logic                   err_clr,
  input  logic                   i_vsync,
  input  logic                   i_valid,
  output logic [COEF_W-1:0]      o_c0,
  output logic [COEF_W-1:0]      o_c1,
  output logic [COEF_W-1:0]      o_c2,
  output logic                   o_pix_en,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_cnt,
  output logic                   o_cfg_err,
  output logic                   o_err_line,
  output logic                   o_err_frame,
  output logic                   o_busy
);

  state_t                 state_q;
  logic [COEF_PACK_W-1:0] coef_q, pend_q;
  logic                   pend_vld_q;
  logic                   frame_done_q, cfg_err_q;
  logic [15:0]            frame_cnt_q;
  logic                   vs_rise;

  video_geom_chk #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT),
    .CW    (CW)
  ) u_geom (
    .clk         (clk),
    .rst         (rst),
    .active_i    (state_q == ACTIVE),
    .vsync_i     (i_vsync),
    .valid_i     (i_valid),
    .err_clr_i   (err_clr),
    .vs_rise_o   (vs_rise),
    .err_line_o  (o_err_line),
    .err_frame_o (o_err_frame)
  );

  // Frame FSM plus coefficient shadow; commit precedes a coincident write so
  // the old pending value lands now and the new one waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      coef_q       <= RST_COEF;
      pend_q       <= RST_COEF;
      pend_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: if (cfg_en) state_q <= WAIT_VS;
        WAIT_VS: begin
          if (vs_rise)      state_q <= ACTIVE;
          else if (!cfg_en) state_q <= IDLE;
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            if (!cfg_en) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (vs_rise && (state_q != IDLE) && pend_vld_q) begin
        coef_q     <= pend_q;
        pend_vld_q <= 1'b0;
      end
      if (cfg_wr) begin
        if (coef_sum(cfg_coef) == 10'(COEF_SUM)) begin
          pend_q     <= cfg_coef;
          pend_vld_q <= 1'b1;
        end else begin
          cfg_err_q  <= 1'b1;
        end
      end
    end
  end

  // Output unpacking and combinational pixel gate
  always_comb begin
    o_c0         = coef_q[C0_LSB +: COEF_W];
    o_c1         = coef_q[C1_LSB +: COEF_W];
    o_c2         = coef_q[C2_LSB +: COEF_W];
    o_pix_en     = i_valid & (state_q == ACTIVE);
    o_busy       = (state_q != IDLE);
    o_frame_done = frame_done_q;
    o_frame_cnt  = frame_cnt_q;
    o_cfg_err    = cfg_err_q;
  end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Directed bench for gray_frame_ctrl on a reduced 8x6 frame geometry.
module tb_gray_frame_ctrl;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst, cfg_en, cfg_wr, err_clr, i_vsync, i_valid;
  logic [23:0] cfg_coef;
  logic [7:0]  o_c0, o_c1, o_c2;
  logic        o_pix_en, o_frame_done, o_cfg_err, o_err_line, o_err_frame, o_busy;
  logic [15:0] o_frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int pix_seen = 0, done_seen = 0, cerr_seen = 0;
  int p0;

  gray_frame_ctrl #(.H_ACT(H), .V_ACT(V), .CW(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .cfg_wr       (cfg_wr),
    .cfg_coef     (cfg_coef),
    .err_clr      (err_clr),
    .i_vsync      (i_vsync),
    .i_valid      (i_valid),
    .o_c0         (o_c0),
    .o_c1         (o_c1),
    .o_c2         (o_c2),
    .o_pix_en     (o_pix_en),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_cfg_err    (o_cfg_err),
    .o_err_line   (o_err_line),
    .o_err_frame  (o_err_frame),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_pix_en === 1'b1)     pix_seen++;
    if (o_frame_done === 1'b1) done_seen++;
    if (o_cfg_err === 1'b1)    cerr_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int npix);
    for (int i = 0; i < npix; i++) begin
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic vsync_edge();
    i_vsync = 1'b1;
    tick();
  endtask

  task automatic vsync_tail();
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_wr = 1'b0; err_clr = 1'b0;
    i_vsync = 1'b0; i_valid = 1'b1; cfg_coef = '0;
    tick(); tick(); tick();
    chk("rst_c0", o_c0, 76);
    chk("rst_c1", o_c1, 150);
    chk("rst_c2", o_c2, 29);
    chk("rst_pix_en", o_pix_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_errs", {o_err_line, o_err_frame, o_frame_done, o_cfg_err}, 0);

    // Enable; a line before the first vsync must not pass
    rst = 1'b0; i_valid = 1'b0; cfg_en = 1'b1;
    tick();
    chk("wait_busy", o_busy, 1);
    p0 = pix_seen;
    send_line(H);
    chk("pre_vs_gate", pix_seen - p0, 0);
    vsync_edge();
    chk("first_vs_nodone", o_frame_done, 0);
    vsync_tail();

    // Frame 1 with a valid coefficient write after line 0
    p0 = pix_seen;
    send_line(H);
    cfg_coef = 24'h646438; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("hold_c0", o_c0, 76);
    for (int l = 1; l < V; l++) send_line(H);
    chk("hold_c1", o_c1, 150);
    chk("f1_pixels", pix_seen - p0, H * V);
    vsync_edge();
    chk("f1_done", o_frame_done, 1);
    chk("f1_fcnt", o_frame_cnt, 1);
    chk("commit_c0", o_c0, 100);
    chk("commit_c1", o_c1, 100);
    chk("commit_c2", o_c2, 56);
    chk("f1_errs", {o_err_line, o_err_frame}, 0);
    vsync_tail();
    chk("done_once", done_seen, 1);

    // Frame 2 with a rejected write (sum 300)
    cfg_coef = 24'h646464; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("cfg_err_pulse", o_cfg_err, 1);
    tick();
    chk("cfg_err_end", o_cfg_err, 0);
    for (int l = 0; l < V; l++) send_line(H);
    vsync_edge();
    chk("f2_fcnt", o_frame_cnt, 2);
    chk("bad_keep_c2", o_c2, 56);
    chk("bad_keep_c0", o_c0, 100);
    vsync_tail();

    // Frame 3: short first line, one line missing
    send_line(H - 1);
    chk("short_line", o_err_line, 1);
    for (int l = 1; l < V - 1; l++) send_line(H);
    chk("frame_err_pre", o_err_frame, 0);
    vsync_edge();
    chk("frame_err", o_err_frame, 1);
    chk("f3_fcnt", o_frame_cnt, 3);
    vsync_tail();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_flags", {o_err_line, o_err_frame}, 0);

    // Frame 4: err_clr coincident with a line error, then write at vs_rise
    for (int i = 0; i < H - 1; i++) begin
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_beats_clr", o_err_line, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_again", o_err_line, 0);
    cfg_coef = 24'h329638; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int l = 1; l < V; l++) send_line(H);
    cfg_coef = 24'h4C961E; cfg_wr = 1'b1;
    vsync_edge();
    cfg_wr = 1'b0;
    chk("f4_fcnt", o_frame_cnt, 4);
    chk("coinc_c0", o_c0, 8'h32);
    chk("coinc_c2", o_c2, 8'h38);
    chk("f4_errf", o_err_frame, 0);
    vsync_tail();

    // Frame 5: disable after line 1; frame still completes
    p0 = pix_seen;
    send_line(H); send_line(H);
    cfg_en = 1'b0;
    for (int l = 2; l < V; l++) send_line(H);
    chk("f5_pixels", pix_seen - p0, H * V);
    chk("f5_busy", o_busy, 1);
    vsync_edge();
    chk("f5_done", o_frame_done, 1);
    chk("f5_fcnt", o_frame_cnt, 5);
    chk("f5_idle", o_busy, 0);
    chk("next_c0", o_c0, 8'h4C);
    chk("next_c2", o_c2, 8'h1E);
    vsync_tail();
    p0 = pix_seen;
    send_line(H);
    chk("post_gate", pix_seen - p0, 0);
    chk("done_total", done_seen, 5);
    chk("cerr_total", cerr_seen, 1);

    // Reset in the middle of a line, with an uncommitted write pending
    cfg_en = 1'b1;
    tick();
    vsync_edge();
    vsync_tail();
    cfg_coef = 24'h646438; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    i_valid = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_pix_en", o_pix_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_pix_en", o_pix_en, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_fcnt", o_frame_cnt, 0);
    chk("mid_rst_c0", o_c0, 76);
    chk("mid_rst_c2", o_c2, 29);
    rst = 1'b0; i_valid = 1'b0;
    tick();
    vsync_edge();
    chk("no_pend_c0", o_c0, 76);
    chk("no_pend_busy", o_busy, 1);
    vsync_tail();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
